alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle integer ALU in the execute stage. Basic operations complete in one cycle. Integer multiply, divide and remainder run on an iterative shift-add / restoring datapath under a start/busy/done handshake, so the core stalls only for long ops. Result flags `zero` and `neg` are registered together with `res`.

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle integer ALU with iterative multiply and divide
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            request, sampled only while busy=0
//   lhs, rhs         operands, sampled with start
//   func             operation code, sampled with start
//   busy             a multiply or divide is in progress
//   done             one-cycle pulse: res/zero/neg newly written
//   res              registered result, held until the next done
//   zero, neg        flags registered together with res
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic [3:0]       func,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             neg
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] F_ADD   = 4'd0;
   localparam logic [3:0] F_SUB   = 4'd1;
   localparam logic [3:0] F_AND   = 4'd2;
   localparam logic [3:0] F_OR    = 4'd3;
   localparam logic [3:0] F_XOR   = 4'd4;
   localparam logic [3:0] F_SLT   = 4'd5;
   localparam logic [3:0] F_SLTU  = 4'd6;
   localparam logic [3:0] F_MUL   = 4'd8;
   localparam logic [3:0] F_MULHU = 4'd9;
   localparam logic [3:0] F_DIV   = 4'd10;
   localparam logic [3:0] F_DIVU  = 4'd11;
   localparam logic [3:0] F_REM   = 4'd12;
   localparam logic [3:0] F_REMU  = 4'd13;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t state, state_nx;

   // opa: multiplicand or divisor magnitude
   // opb: multiplier (shifts right) or dividend/quotient (shifts left)
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     opa, opb, rem;
   logic [2*WIDTH-1:0]   acc;
   logic [3:0]           op;
   logic                 lsgn, rsgn;

   logic                 is_mul, is_div, div_sgn, special, last;
   logic [WIDTH-1:0]     min_neg, basic_res, special_res, lhs_mag, rhs_mag;
   logic [WIDTH:0]       mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0]   acc_step;
   logic [WIDTH-1:0]     rem_step, quo_step, q_fix, r_fix;
   logic                 wr_en;
   logic [WIDTH-1:0]     wr_val;

   // request decode and single-cycle results
   always_comb begin
      is_mul  = (func == F_MUL) || (func == F_MULHU);
      is_div  = (func == F_DIV) || (func == F_DIVU) || (func == F_REM) || (func == F_REMU);
      div_sgn = (func == F_DIV) || (func == F_REM);
      min_neg = {1'b1, {(WIDTH-1){1'b0}}};
      special = (rhs == '0) || (div_sgn && (lhs == min_neg) && (rhs == '1));
      lhs_mag = (div_sgn && lhs[WIDTH-1]) ? -lhs : lhs;
      rhs_mag = (div_sgn && rhs[WIDTH-1]) ? -rhs : rhs;

      case (func)
         F_SUB:   basic_res = lhs - rhs;
         F_AND:   basic_res = lhs & rhs;
         F_OR:    basic_res = lhs | rhs;
         F_XOR:   basic_res = lhs ^ rhs;
         F_SLT:   basic_res = {{(WIDTH-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
         F_SLTU:  basic_res = {{(WIDTH-1){1'b0}}, (lhs < rhs)};
         default: basic_res = lhs + rhs;
      endcase

      if (rhs == '0)
         special_res = ((func == F_DIV) || (func == F_DIVU)) ? '1 : lhs;
      else
         special_res = (func == F_DIV) ? lhs : '0;
   end

   // one iteration of shift-add multiply and restoring divide
   always_comb begin
      last     = (cnt == CW'(WIDTH-1));
      // add the multiplicand into the upper half, then shift the whole accumulator right
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
      acc_step = {mul_sum, acc[WIDTH-1:1]};
      // shift the next dividend bit into the partial remainder and trial-subtract
      div_sh   = {rem, opb[WIDTH-1]};
      div_diff = div_sh - {1'b0, opa};
      rem_step = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      quo_step = {opb[WIDTH-2:0], ~div_diff[WIDTH]};
      q_fix    = ((op == F_DIV) && (lsgn ^ rsgn)) ? -opb : opb;
      r_fix    = ((op == F_REM) && lsgn) ? -rem : rem;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start && is_mul)
               state_nx = S_MUL;
            else if (start && is_div && !special)
               state_nx = S_DIV;
         end
         S_MUL:   if (last) state_nx = S_IDLE;
         S_DIV:   if (last) state_nx = S_FIX;
         default: state_nx = S_IDLE;
      endcase
   end

   // outputs: busy and the result write strobe
   always_comb begin
      busy   = (state != S_IDLE);
      wr_en  = 1'b0;
      wr_val = basic_res;
      case (state)
         S_IDLE: begin
            if (start && is_div) begin
               wr_en  = special;
               wr_val = special_res;
            end else if (start && !is_mul) begin
               wr_en  = 1'b1;
               wr_val = basic_res;
            end
         end
         S_MUL: begin
            wr_en  = last;
            wr_val = (op == F_MULHU) ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
         end
         S_FIX: begin
            wr_en  = 1'b1;
            wr_val = ((op == F_DIV) || (op == F_DIVU)) ? q_fix : r_fix;
         end
         default: ;
      endcase
   end

   // datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         opa  <= '0;
         opb  <= '0;
         rem  <= '0;
         acc  <= '0;
         op   <= '0;
         lsgn <= 1'b0;
         rsgn <= 1'b0;
         res  <= '0;
         zero <= 1'b1;
         neg  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= wr_en;
         if (wr_en) begin
            res  <= wr_val;
            zero <= (wr_val == '0);
            neg  <= wr_val[WIDTH-1];
         end
         case (state)
            S_IDLE: begin
               if (start && (is_mul || (is_div && !special))) begin
                  op  <= func;
                  cnt <= '0;
                  acc <= '0;
                  rem <= '0;
                  if (is_mul) begin
                     opa  <= lhs;
                     opb  <= rhs;
                     lsgn <= 1'b0;
                     rsgn <= 1'b0;
                  end else begin
                     opa  <= rhs_mag;
                     opb  <= lhs_mag;
                     lsgn <= div_sgn & lhs[WIDTH-1];
                     rsgn <= div_sgn & rhs[WIDTH-1];
                  end
               end
            end
            S_MUL: begin
               acc <= acc_step;
               opb <= opb >> 1;
               cnt <= cnt + CW'(1);
            end
            S_DIV: begin
               rem <= rem_step;
               opb <= quo_step;
               cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] lhs, rhs;
   logic [3:0]  func;
   logic        busy, done;
   logic [31:0] res;
   logic        zero, neg;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .lhs   (lhs),
      .rhs   (rhs),
      .func  (func),
      .busy  (busy),
      .done  (done),
      .res   (res),
      .zero  (zero),
      .neg   (neg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sb;
      logic               ovf;
      p   = {32'b0, a} * {32'b0, b};
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd6:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return p[31:0];
         4'd9:  return p[63:32];
         4'd10: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd12: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         4'd13: return (b == 0) ? a : a % b;
         default: return a + b;
      endcase
   endfunction

   function automatic int latency(input logic [3:0] f, input logic [31:0] b);
      if (f == 4'd8 || f == 4'd9) return 33;
      if (f >= 4'd10 && f <= 4'd13) begin
         if (b == 0) return 1;
         if ((f == 4'd10 || f == 4'd12) && b == 32'hFFFF_FFFF) return 1;  // only special with most-negative lhs
         return 34;
      end
      return 1;
   endfunction

   // runs one operation; poke>0 pulses a stray start with fresh operands at that edge count
   task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int poke);
      logic [31:0] exp;
      int          lat, n, berr;
      exp = model(f, a, b);
      lat = latency(f, b);
      if (lat == 1 && (f == 4'd10 || f == 4'd12) && b == 32'hFFFF_FFFF && a != 32'h8000_0000)
         lat = 34;
      @(negedge clk);
      start = 1'b1; func = f; lhs = a; rhs = b;
      @(posedge clk); #1;
      start = 1'b0; lhs = $urandom; rhs = $urandom; func = 4'($urandom);
      n = 1;
      berr = 0;
      while (done !== 1'b1 && n < 200) begin
         if (busy !== (lat > 1)) berr++;
         start = (n == poke);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk($sformatf("lat f=%0d", f), 64'(n), 64'(lat));
      chk($sformatf("res f=%0d a=%0h b=%0h", f, a, b), 64'(res), 64'(exp));
      chk("zero", 64'(zero), 64'(exp == 0));
      chk("neg", 64'(neg), 64'(exp[31]));
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("busy_during", 64'(berr), 64'(0));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'(-$urandom_range(1, 20));
         4: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int dn;
      logic [31:0] held;
      rst = 1'b1; start = 1'b0; lhs = '0; rhs = '0; func = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_res", 64'(res), 64'(0));
      chk("rst_zero", 64'(zero), 64'(1));
      chk("rst_neg", 64'(neg), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));

      // rst and start on the same edge: start dropped
      @(negedge clk);
      start = 1'b1; func = 4'd0; lhs = 32'd3; rhs = 32'd4;
      @(posedge clk); #1;
      chk("rst_start_done", 64'(done), 64'(0));
      chk("rst_start_res", 64'(res), 64'(0));
      @(negedge clk);
      start = 1'b0; rst = 1'b0;

      do_op(4'd0, 32'd5, 32'hFFFF_FFF9, 0);
      do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(4'd8, 32'd7, 32'd6, 5);
      held = res;
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("res_held", 64'(res), 64'(held));
      do_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(4'd10, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(4'd12, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(4'd11, 32'd100, 32'd7, 0);
      do_op(4'd13, 32'd100, 32'd7, 0);
      do_op(4'd11, 32'd9, 32'd0, 0);
      do_op(4'd12, 32'd9, 32'd0, 0);
      do_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(4'd10, 32'h8000_0000, 32'd3, 7);
      do_op(4'd13, 32'd100, 32'd7, 0);

      // reset at edge 10 of a DIV
      @(negedge clk);
      start = 1'b1; func = 4'd10; lhs = 32'hFFFF_FFF9; rhs = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_res", 64'(res), 64'(0));
      chk("abort_zero", 64'(zero), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dn++;
      end
      chk("abort_quiet", 64'(dn), 64'(0));
      do_op(4'd0, 32'd1, 32'd1, 0);

      for (int i = 0; i < 80; i++)
         do_op(4'($urandom_range(0, 15)), pick(), pick(), (i % 5 == 0) ? 3 : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
